mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning data-memory address width.
REQ-002 SHALL have parameter DW, default 32, meaning data-memory word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 16, meaning the blocked-cycle count at which device starvation is flagged (range 1..255).
REQ-004 SHALL have ports, one per line, as follows:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_read  in  1  CPU read request, valid per cycle.
- cpu_write  in  1  CPU write request, valid per cycle.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data.
- dev_req  in  1  device request valid; fields held stable while high.
- dev_we  in  1  device write (1) or read (0).
- dev_addr  in  AW  device address.
- dev_wdata  in  DW  device write data.
- dev_ready  out  1  arbiter can accept a device request.
- dev_done  out  1  one-cycle completion pulse.
- dev_rdata  out  DW  device read data, valid while dev_done=1.
- dev_starve  out  1  device blocked for at least STARVE_LIMIT cycles.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, combinational from mem_addr in the same cycle.

Function
REQ-005 SHALL give the CPU absolute priority: in any cycle with cpu_read|cpu_write, the mem_* outputs SHALL be driven combinationally from the cpu_* inputs, with mem_en=1.
REQ-006 SHALL, when cpu_read and cpu_write are both high, perform the write (mem_we=1).
REQ-007 SHALL drive cpu_rdata=mem_rdata combinationally in every cycle, so that a CPU read is satisfied with zero added latency.
REQ-008 SHALL implement three states, IDLE, PEND and DONE, with dev_ready=1 only in IDLE.
REQ-009 SHALL accept a device request at a rising edge where dev_req=1 and dev_ready=1, latching dev_we, dev_addr and dev_wdata, and SHALL then go IDLE->PEND.
REQ-010 SHALL treat a PEND cycle with cpu_read=0 and cpu_write=0 as a grant cycle, driving mem_en=1, mem_we=latched we, and mem_addr/mem_wdata from the latched fields.
REQ-011 SHALL, at the edge ending a grant cycle, capture mem_rdata into dev_rdata (for reads only; a write leaves dev_rdata unchanged) and go PEND->DONE.
REQ-012 SHALL, in PEND cycles where the CPU is active, remain in PEND; the device access SHALL NOT be issued or corrupted.
REQ-013 SHALL assert dev_done=1 for exactly the one cycle spent in DONE, then go DONE->IDLE.
REQ-014 SHALL give a minimum latency of: accept at edge E0, grant in cycle E0..E1, dev_done high in cycle E1..E2, and dev_ready high again from E2.
REQ-015 SHALL keep an 8-bit wait counter that clears on entry to PEND, increments saturating at 255 on each blocked PEND cycle, and is ignored outside PEND.
REQ-016 SHALL register dev_starve: it is 1 while in PEND with wait counter >= STARVE_LIMIT, and 0 from the first cycle after leaving PEND.
REQ-017 SHALL drive mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0 when neither the CPU nor a device grant owns the bus, with no X values on outputs.
REQ-018 SHALL ignore dev_req while in PEND or DONE, and SHALL NOT let changes to dev_* fields after acceptance affect the pending access.

Reset
REQ-019 SHALL, on rst=1 at a rising edge, set state=IDLE, dev_done=0, dev_starve=0, dev_rdata=0, wait counter=0 and latched fields=0.
REQ-020 SHALL, on reset during PEND or DONE, abort the device access: no dev_done pulse, no memory access issued, and dev_ready=1 in the first cycle after reset.
REQ-021 SHALL leave the CPU path purely combinational and unaffected by rst.

Verification
REQ-022 SHALL verify device read with CPU idle: mem[0x10]=0xCAFEF00D, device reads 0x10 -> dev_done pulses 1 cycle after grant with dev_rdata=0xCAFEF00D, and dev_ready returns 2 cycles after accept.
REQ-023 SHALL verify CPU preemption: device write of 0x55 to 0x20 accepted, then CPU reads for 3 consecutive cycles -> no device access during those cycles, grant occurs in cycle 4, and mem[0x20]=0x55 afterwards.
REQ-024 SHALL verify starvation: STARVE_LIMIT=4 with the CPU busy for 6 cycles after accept -> dev_starve rises after 4 blocked cycles, stays high until the grant, and clears the cycle after leaving PEND.
REQ-025 SHALL verify simultaneous CPU read/write: cpu_read=cpu_write=1 at address 0x05 with data 0x1234 -> mem_we=1, and mem[0x05]=0x1234.
REQ-026 SHALL verify reset mid-PEND: rst asserted while blocked in PEND -> no dev_done pulse, no memory write, and dev_ready=1 the cycle after reset.
REQ-027 SHALL verify back-to-back device requests: dev_req held high across two requests -> second request accepted on the edge dev_ready=1, with one dev_done pulse per request.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory arbiter: the CPU owns the memory port combinationally whenever it asks for it;
// a single device request is buffered and issued in the first cycle the CPU leaves free.
module mem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dev_req,
  input  logic          dev_we,
  input  logic [AW-1:0] dev_addr,
  input  logic [DW-1:0] dev_wdata,
  output logic          dev_ready,
  output logic          dev_done,
  output logic [DW-1:0] dev_rdata,
  output logic          dev_starve,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t        state;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [7:0]    wait_cnt;
  logic [7:0]    wait_next;
  logic          cpu_active;
  logic          grant;

  assign cpu_active = cpu_read | cpu_write;
  // A pending access is never issued in a reset cycle, so an aborted request cannot touch memory.
  assign grant      = (state == PEND) && !cpu_active && !rst;
  assign wait_next  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign cpu_rdata  = mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_active) begin
      mem_en    = 1'b1;
      mem_we    = cpu_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grant) begin
      mem_en    = 1'b1;
      mem_we    = lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dev_ready  <= 1'b1;
      dev_done   <= 1'b0;
      dev_starve <= 1'b0;
      dev_rdata  <= '0;
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          dev_done   <= 1'b0;
          dev_starve <= 1'b0;
          if (dev_req) begin
            lat_we    <= dev_we;
            lat_addr  <= dev_addr;
            lat_wdata <= dev_wdata;
            wait_cnt  <= '0;
            dev_ready <= 1'b0;
            state     <= PEND;
          end
        end
        PEND: begin
          if (cpu_active) begin
            wait_cnt   <= wait_next;
            dev_starve <= (wait_next >= LIMIT);
          end else begin
            if (!lat_we) dev_rdata <= mem_rdata;
            dev_starve <= 1'b0;
            dev_done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          dev_done  <= 1'b0;
          dev_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          dev_done   <= 1'b0;
          dev_starve <= 1'b0;
          dev_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
